// File: rtl/ita37_scroll_buf_if.sv
// Write port of the ita37 scroll buffer: one character per valid/ready beat.
// A beat transfers when wr_valid and wr_ready are both high on a rising clk
// edge; wr_char and wr_last are only meaningful in that cycle, and the
// master holds them stable while wr_valid is high.
interface ita37_scroll_buf_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [5:0] wr_char;
   logic       wr_last;

   modport master (
      output wr_valid,
      output wr_char,
      output wr_last,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_char,
      input  wr_last,
      output wr_ready
   );
endinterface

// File: rtl/ita37_scroll_buf.sv
// ita37_scroll_buf: message buffer feeding the 12-digit 14-segment scanner.
// Characters arrive over the write interface; once a message is committed
// a DIGITS-wide window of it is shown and, if longer than the window,
// scrolls circularly one character every SCROLL_DIV enabled cycles.
// seg_pattern is registered: it answers the digit_idx sampled one edge earlier.
module ita37_scroll_buf #(
   parameter int MAX_LEN    = 32,
   parameter int DIGITS     = 12,
   parameter int SCROLL_DIV = 1000000
) (
`ifdef USE_POWER_PINS
   inout  wire          vdd,
   inout  wire          vss,
`endif
   input  logic         clk,
   input  logic         rst,
   ita37_scroll_buf_if.slave wr,
   input  logic         scroll_en,
   input  logic [3:0]   digit_idx,
   output logic [13:0]  seg_pattern,
   output logic [5:0]   msg_len,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int PW = $clog2(SCROLL_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCROLL_DIV - 1);
   localparam logic [AW-1:0] IDX_LAST   = AW'(MAX_LEN - 1);
   localparam logic [5:0]    DIGITS6    = 6'(DIGITS);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q;
   logic [5:0]      offset_q;
   logic [PW-1:0]   presc_q;
   logic [5:0]      mem [MAX_LEN];

   logic            hs;
   logic            commit;
   logic [AW-1:0]   wr_idx;
   logic            scroll_ok;
   logic            presc_tc;
   logic [5:0]      rd_pos;
   logic [5:0]      rd_sum;
   logic            rd_blank;
   logic            unused_rd_hi;

   // Team 14-segment font, bit order a b c d e f g1 g2 h j k l m n (MSB first).
   function automatic logic [13:0] font14(input logic [5:0] code);
      logic [13:0] p;
      case (code)
         6'd0:  p = 14'b111111_00_001001;
         6'd1:  p = 14'b011000_00_001000;
         6'd2:  p = 14'b110110_11_000000;
         6'd3:  p = 14'b111100_01_000000;
         6'd4:  p = 14'b011001_11_000000;
         6'd5:  p = 14'b101101_11_000000;
         6'd6:  p = 14'b101111_11_000000;
         6'd7:  p = 14'b111000_00_000000;
         6'd8:  p = 14'b111111_11_000000;
         6'd9:  p = 14'b111101_11_000000;
         6'd10: p = 14'b111011_11_000000; // A
         6'd11: p = 14'b111100_01_010010; // B
         6'd12: p = 14'b100111_00_000000; // C
         6'd13: p = 14'b111100_00_010010; // D
         6'd14: p = 14'b100111_10_000000; // E
         6'd15: p = 14'b100011_10_000000; // F
         6'd16: p = 14'b101111_01_000000; // G
         6'd17: p = 14'b011011_11_000000; // H
         6'd18: p = 14'b100100_00_010010; // I
         6'd19: p = 14'b011110_00_000000; // J
         6'd20: p = 14'b000011_10_001100; // K
         6'd21: p = 14'b000111_00_000000; // L
         6'd22: p = 14'b011011_00_101000; // M
         6'd23: p = 14'b011011_00_100100; // N
         6'd24: p = 14'b111111_00_000000; // O
         6'd25: p = 14'b110011_11_000000; // P
         6'd26: p = 14'b111111_00_000100; // Q
         6'd27: p = 14'b110011_11_000100; // R
         6'd28: p = 14'b101101_11_000000; // S
         6'd29: p = 14'b100000_00_010010; // T
         6'd30: p = 14'b011111_00_000000; // U
         6'd31: p = 14'b000011_00_001001; // V
         6'd32: p = 14'b011011_00_000101; // W
         6'd33: p = 14'b000000_00_101101; // X
         6'd34: p = 14'b000000_00_101010; // Y
         6'd35: p = 14'b100100_00_001001; // Z
         default: p = 14'b000000_00_000000; // space and 37..63 are blank
      endcase
      return p;
   endfunction

   assign wr.wr_ready = 1'b1;

   // Handshake decode: first beat of a message always lands at index 0.
   always_comb begin
      hs     = wr.wr_valid & wr.wr_ready;
      wr_idx = (state_q == ST_LOAD) ? ptr_q : '0;
      commit = hs & (wr.wr_last | (wr_idx == IDX_LAST));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // Next state: any beat starts or continues a load; a committing beat shows.
   always_comb begin
      state_d = state_q;
      if (hs) state_d = commit ? ST_SHOW : ST_LOAD;
   end

   // State-derived outputs and scroll qualification.
   always_comb begin
      busy      = (state_q == ST_LOAD);
      dbg_state = state_q;
      scroll_ok = (state_q == ST_SHOW) & scroll_en & (msg_len > DIGITS6);
      presc_tc  = (presc_q == PRESC_LAST);
   end

   // Write pointer, committed length, prescaler and window offset; a beat
   // always wins over a scroll step on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= '0;
         msg_len  <= '0;
         offset_q <= '0;
         presc_q  <= '0;
      end else if (hs) begin
         ptr_q    <= wr_idx + AW'(1);
         msg_len  <= commit ? (6'(wr_idx) + 6'd1) : 6'd0;
         offset_q <= '0;
         presc_q  <= '0;
      end else if (scroll_ok) begin
         if (presc_tc) begin
            presc_q  <= '0;
            offset_q <= (offset_q == msg_len - 6'd1) ? 6'd0 : offset_q + 6'd1;
         end else begin
            presc_q  <= presc_q + PW'(1);
         end
      end
   end

   // Character store; contents need no reset since msg_len gates every read.
   always_ff @(posedge clk) begin
      if (hs) mem[wr_idx] <= wr.wr_char;
   end

   // Window address: offset+p stays below 2*msg_len, so one subtract wraps it.
   always_comb begin
      rd_pos = {2'b00, digit_idx};
      rd_sum = offset_q + rd_pos;
      if (rd_sum >= msg_len) rd_sum = rd_sum - msg_len;
      rd_blank = (state_q != ST_SHOW) | (rd_pos >= DIGITS6) |
                 ((msg_len <= DIGITS6) & (rd_pos >= msg_len));
      unused_rd_hi = ^rd_sum[5:AW];
   end

   // Registered segment lookup for the requested digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           seg_pattern <= '0;
      else if (rd_blank) seg_pattern <= '0;
      else               seg_pattern <= font14(mem[rd_sum[AW-1:0]]);
   end

endmodule

// File: tb/tb_ita37_scroll_buf.sv
// Directed bench for ita37_scroll_buf: reset, short/long messages, blanking,
// scrolling with SCROLL_DIV=4, implicit commit at MAX_LEN and async reset.
module tb_ita37_scroll_buf;
   localparam int SDIV = 4;

   localparam logic [13:0] PAT_P = 14'b11001111000000;
   localparam logic [13:0] PAT_O = 14'b11111100000000;
   localparam logic [13:0] PAT_0 = 14'b11111100001001;
   localparam logic [13:0] PAT_2 = 14'b11011011000000;

   localparam logic [5:0] C_0 = 6'd0,  C_2 = 6'd2,  C_C = 6'd12, C_E = 6'd14;
   localparam logic [5:0] C_H = 6'd17, C_L = 6'd21, C_O = 6'd24, C_P = 6'd25;
   localparam logic [5:0] C_S = 6'd28, C_X = 6'd33;

   logic        clk = 1'b0;
   logic        rst;
   logic        scroll_en;
   logic [3:0]  digit_idx;
   logic [13:0] seg_pattern;
   logic [5:0]  msg_len;
   logic        busy;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [5:0] msg14 [14];

   ita37_scroll_buf_if wr_if();

   ita37_scroll_buf #(
      .MAX_LEN    (32),
      .DIGITS     (12),
      .SCROLL_DIV (SDIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr          (wr_if),
      .scroll_en   (scroll_en),
      .digit_idx   (digit_idx),
      .seg_pattern (seg_pattern),
      .msg_len     (msg_len),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic logic [13:0] pat(input logic [5:0] code);
      case (code)
         C_P:     return PAT_P;
         C_O:     return PAT_O;
         C_0:     return PAT_0;
         C_2:     return PAT_2;
         default: return 14'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [5:0] c, input logic last);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_char  = c;
      wr_if.wr_last  = last;
      @(posedge clk); #1;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_last  = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] d, input logic [13:0] exp);
      digit_idx = d;
      @(posedge clk); #1;
      check($sformatf("%s_d%0d", tag, d), seg_pattern, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance the window by k steps: scroll_en high for exactly k*SDIV edges.
   task automatic scroll_steps(input int k);
      scroll_en = 1'b1;
      idle(k * SDIV);
      scroll_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      scroll_en = 1'b0;
      digit_idx = 4'd0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_char  = 6'd0;
      wr_if.wr_last  = 1'b0;
      msg14 = '{C_P, C_O, C_0, C_2, C_O, C_0, C_2, C_O, C_0, C_2, C_O, C_0, C_O, C_2};

      // Reset values
      idle(2);
      check("rst_msg_len", msg_len, 6'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_ready", wr_if.wr_ready, 1'b1);
      check("rst_state", dbg_state, 2'd0);
      check("rst_seg", seg_pattern, 14'd0);
      rst = 1'b0;
      for (int d = 0; d < 12; d++) read_chk("empty", 4'(d), 14'd0);

      // 12-char message POSOCO2000XX, scrolling enabled but must not move
      scroll_en = 1'b1;
      send(C_P, 0); send(C_O, 0); send(C_S, 0); send(C_O, 0);
      send(C_C, 0); send(C_O, 0); send(C_2, 0); send(C_0, 0);
      send(C_0, 0); send(C_0, 0); send(C_X, 0); send(C_X, 1);
      check("m12_len", msg_len, 6'd12);
      check("m12_busy", busy, 1'b0);
      check("m12_state", dbg_state, 2'd2);
      read_chk("m12", 4'd0, PAT_P);
      read_chk("m12", 4'd1, PAT_O);
      read_chk("m12", 4'd5, PAT_O);
      read_chk("m12", 4'd6, PAT_2);
      read_chk("m12", 4'd7, PAT_0);
      read_chk("m12", 4'd9, PAT_0);
      idle(20);
      read_chk("m12_noscroll", 4'd0, PAT_P);
      read_chk("m12_noscroll", 4'd7, PAT_0);
      scroll_en = 1'b0;

      // HELLO: blank while loading, blank past the message and past DIGITS
      send(C_H, 0);
      check("hello_busy", busy, 1'b1);
      check("hello_len_clr", msg_len, 6'd0);
      check("hello_state", dbg_state, 2'd1);
      read_chk("hello_load", 4'd0, 14'd0);
      send(C_E, 0); send(C_L, 0); send(C_L, 0); send(C_O, 1);
      check("hello_len", msg_len, 6'd5);
      read_chk("hello", 4'd4, PAT_O);
      for (int d = 5; d < 16; d++) read_chk("hello_blank", 4'(d), 14'd0);

      // Single-character message
      send(C_O, 1);
      check("one_len", msg_len, 6'd1);
      check("one_busy", busy, 1'b0);
      read_chk("one", 4'd0, PAT_O);
      read_chk("one", 4'd1, 14'd0);

      // 14-char message, scrolling
      for (int i = 0; i < 14; i++) send(msg14[i], (i == 13));
      check("m14_len", msg_len, 6'd14);
      read_chk("m14_off0", 4'd0, pat(msg14[0]));
      read_chk("m14_off0", 4'd11, pat(msg14[11]));
      scroll_en = 1'b1;
      idle(SDIV - 1);
      scroll_en = 1'b0;
      read_chk("m14_presc3", 4'd0, pat(msg14[0]));
      scroll_en = 1'b1;
      idle(1);
      scroll_en = 1'b0;
      read_chk("m14_off1", 4'd0, pat(msg14[1]));
      read_chk("m14_off1", 4'd11, pat(msg14[12]));
      scroll_steps(12);
      read_chk("m14_off13", 4'd0, pat(msg14[13]));
      read_chk("m14_off13", 4'd1, pat(msg14[0]));
      read_chk("m14_off13", 4'd2, pat(msg14[1]));
      scroll_steps(1);
      read_chk("m14_wrap", 4'd0, pat(msg14[0]));
      read_chk("m14_wrap", 4'd1, pat(msg14[1]));

      // 32 chars without wr_last: implicit commit on the last index
      for (int i = 0; i < 31; i++) send((i % 2 == 0) ? C_P : C_O, 0);
      check("m32_busy31", busy, 1'b1);
      check("m32_len31", msg_len, 6'd0);
      send(C_O, 0);
      check("m32_len", msg_len, 6'd32);
      check("m32_busy", busy, 1'b0);
      check("m32_state", dbg_state, 2'd2);
      read_chk("m32", 4'd0, PAT_P);
      read_chk("m32", 4'd1, PAT_O);
      send(C_P, 0);
      check("m33_busy", busy, 1'b1);
      check("m33_len", msg_len, 6'd0);
      read_chk("m33_blank", 4'd0, 14'd0);

      // Asynchronous reset after 3 characters of a load
      send(C_O, 0); send(C_2, 0);
      check("pre_rst_busy", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_len", msg_len, 6'd0);
      check("arst_state", dbg_state, 2'd0);
      check("arst_seg", seg_pattern, 14'd0);
      check("arst_ready", wr_if.wr_ready, 1'b1);
      idle(1);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) read_chk("arst_blank", 4'(d), 14'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
